wormhole_rr_arbiter: RTL and testbench
======================================

// Module: wormhole_rr_arbiter
// PURPOSE
// - Per-output-port arbiter: shares one router output module between N_REQ input modules that target it.
// - Round-robin grant on head flits. Grant is locked for the whole wormhole packet and released after the tail flit transfers.
// - Drives the one-hot select that steers the winner's flit and response through the output mux.
// PARAMETERS
// - N_REQ          4    number of requesting input modules (one per non-self port)
// - TIMEOUT_CYCLES 256  stall limit while locked; used only with ARB_TIMEOUT_EN
// PORTS
// - clk          in   1      clock
// - arst         in   1      reset, synchronous, active-high (sampled on rising clk)
// - req_valid_i  in   N_REQ  flit valid from each requester towards this output
// - req_tail_i   in   N_REQ  flit on req lane i is a tail (or a single-flit packet)
// - out_ready_i  in   1      downstream output module accepts a flit this cycle
// - grant_o      out  N_REQ  one-hot select of the current owner; 0 if none
// - req_ready_o  out  N_REQ  req_ready_o[i] = grant_o[i] & out_ready_i
// - out_valid_o  out  1      |(grant_o & req_valid_i)
// - locked_o     out  1      arbiter is in LOCKED state
// - timeout_o    out  1      1-cycle pulse on forced release (ARB_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
// - State: IDLE, LOCKED. Registers: state, owner (one-hot), rr_ptr (log2 N_REQ).
// - Reset values: state = IDLE, owner = 0, rr_ptr = 0, timeout_o = 0. While arst is high all outputs are 0.
// - IDLE:
//   - grant_o is combinational: the first asserted req_valid_i searching from rr_ptr upward, wrapping N_REQ-1 -> 0.
//   - No valid request -> grant_o = 0.
//   - Zero latency: a head flit can transfer in the cycle it first appears.
// - Transfer: xfer = out_valid_o & out_ready_i.
// - IDLE & xfer & ~tail of the winner -> LOCKED, owner <= winner.
// - IDLE & xfer & tail of the winner (single-flit packet) -> stay IDLE, rr_ptr <= winner_idx + 1 (mod N_REQ).
// - LOCKED:
//   - grant_o = owner regardless of other requests.
//   - The owner dropping valid (bubble) keeps the lock. out_valid_o = 0 in that cycle.
// - LOCKED & xfer & req_tail_i[owner] -> IDLE next cycle, owner <= 0, rr_ptr <= owner_idx + 1.
// - Re-arbitration happens the cycle after the tail. There is no same-cycle handover.
// - out_ready_i low: nothing transfers, state and rr_ptr hold, the IDLE grant can still change as requests change.
// - Requests with valid low are never granted in IDLE. Lanes other than the owner are ignored while LOCKED.
// - rr_ptr wraps with mod N_REQ; when N_REQ is not a power of 2, the wrap is explicit.
// - Reset asserted mid-packet: the lock is dropped immediately (next edge) and rr_ptr returns to 0. The partial packet is the upstream's responsibility.
// CONFIGURATION
// - Macro ARB_TIMEOUT_EN, defined:
//   - A stall counter counts cycles in LOCKED with no xfer and clears on any xfer.
//   - When it reaches TIMEOUT_CYCLES-1, the next state is IDLE, rr_ptr advances past the owner, and timeout_o pulses for 1 cycle.
// - Macro ARB_TIMEOUT_EN, not defined:
//   - No counter exists and the lock is held indefinitely.
//   - timeout_o = 0 constant. TIMEOUT_CYCLES is unused.
// STRUCTURE
// - Shared package ravenoc_pkg gains:
//   - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t
//   - localparam N_ARB_REQ = 4
//   - the default for TIMEOUT_CYCLES
// - Sub-module rr_pick:
//   - Combinational, parameter N.
//   - Inputs req[N], ptr. Outputs one-hot gnt[N], gnt_idx.
//   - Double-width masked priority search.
// - One wormhole_rr_arbiter instance sits inside each of the 5 output modules.
// TESTING
// - Reset, then no requests -> grant_o = 0, out_valid_o = 0, locked_o = 0, rr_ptr = 0.
// - Fairness with single-flit packets:
//   - Stimulus: req_valid_i = 4'b1111, tail = 4'b1111, out_ready_i = 1 for 8 cycles.
//   - Required: grant_o sequence 0001, 0010, 0100, 1000, 0001, ...
// - Wormhole lock:
//   - Stimulus: req 0 sends a 4-flit packet while req 2 stays valid.
//   - Required: grant_o = 0001 for 4 xfers. locked_o is high after flit 1, and low the cycle after the tail. Next grant = 0100.
// - Backpressure and bubble:
//   - Stimulus: hold out_ready_i = 0 for 5 cycles mid-packet, then drop the owner's valid for 2 cycles.
//   - Required: grant_o stays at the owner, no xfer, state stays LOCKED.
// - Pointer wrap: owner 3 sends a tail with req_valid_i = 4'b1001 -> next grant = 0001.
// - ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8:
//   - Stimulus: owner 1 locks, then its valid stays low for 8 cycles while req 2 is valid.
//   - Required: timeout_o pulses once, and the next grant = 0100.
//   - Also: arst pulses while LOCKED -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/ravenoc_pkg.sv
// Shared router package: arbiter state encoding and arbiter defaults.
package ravenoc_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int N_ARB_REQ          = 4;
  localparam int ARB_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/wormhole_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req at or above ptr, wrapping.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  localparam int W2 = 2 * N;

  logic [W2-1:0] dbl, mask, masked;
  logic          found;

  // Upper copy of req supplies the wrapped-around candidates below ptr.
  always_comb begin
    dbl     = {req, req};
    mask    = ~((W2'(1) << ptr) - W2'(1));
    masked  = dbl & mask;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < W2; i++) begin
      if (!found && masked[i]) begin
        found        = 1'b1;
        gnt_idx      = IW'(i % N);
        gnt[i % N]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wormhole_rr_arbiter.sv
// Per-output wormhole arbiter: round-robin on heads, locked until tail transfers.
// Optional stall release under macro ARB_TIMEOUT_EN.
module wormhole_rr_arbiter
  import ravenoc_pkg::*;
#(
  parameter int N_REQ          = N_ARB_REQ,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [N_REQ-1:0] req_tail_i,
  input  logic             out_ready_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [N_REQ-1:0] req_ready_o,
  output logic             out_valid_o,
  output logic             locked_o,
  output logic             timeout_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state;
  logic [N_REQ-1:0] owner, pick_gnt;
  logic [IW-1:0]    rr_ptr, pick_idx, owner_idx, win_idx, nxt_ptr;
  logic             xfer, win_tail;

  rr_pick #(.N(N_REQ)) u_pick (
    .req     (req_valid_i),
    .ptr     (rr_ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (owner[i]) owner_idx = IW'(i);
  end

  // Reset forces every output low, including the combinational IDLE grant.
  assign grant_o     = arst ? '0 : ((state == ARB_LOCKED) ? owner : pick_gnt);
  assign req_ready_o = grant_o & {N_REQ{out_ready_i}};
  assign out_valid_o = |(grant_o & req_valid_i);
  assign locked_o    = ~arst & (state == ARB_LOCKED);
  assign xfer        = out_valid_o & out_ready_i;
  assign win_tail    = |(grant_o & req_tail_i);
  assign win_idx     = (state == ARB_LOCKED) ? owner_idx : pick_idx;
  assign nxt_ptr     = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] stall_cnt;
  logic          timeout_q;
  logic          stall_hit;

  assign stall_hit = (state == ARB_LOCKED) && !xfer && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_o = timeout_q & ~arst;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (arst) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
`ifdef ARB_TIMEOUT_EN
      stall_cnt <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
      if (state == ARB_LOCKED && !xfer && !stall_hit) stall_cnt <= stall_cnt + CW'(1);
      else                                            stall_cnt <= '0;
`endif
      case (state)
        ARB_IDLE: begin
          if (xfer) begin
            if (win_tail) rr_ptr <= nxt_ptr;
            else begin
              state <= ARB_LOCKED;
              owner <= pick_gnt;
            end
          end
        end
        ARB_LOCKED: begin
          if (xfer && win_tail) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= nxt_ptr;
          end
`ifdef ARB_TIMEOUT_EN
          else if (stall_hit) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            rr_ptr    <= nxt_ptr;
            timeout_q <= 1'b1;
          end
`endif
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wormhole_rr_arbiter.sv
// Directed bench for wormhole_rr_arbiter; timeout checks follow ARB_TIMEOUT_EN.
module tb_wormhole_rr_arbiter;

  logic       clk = 1'b0;
  logic       arst;
  logic [3:0] req_valid, req_tail, grant, req_ready;
  logic       out_ready, out_valid, locked, timeout;

  int nvec = 0;
  int nmis = 0;

  wormhole_rr_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .arst        (arst),
    .req_valid_i (req_valid),
    .req_tail_i  (req_tail),
    .out_ready_i (out_ready),
    .grant_o     (grant),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .locked_o    (locked),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic ov, input logic lk);
    chk({tag, ".gnt"}, grant, g);
    chk({tag, ".vld"}, out_valid, ov);
    chk({tag, ".lck"}, locked, lk);
  endtask

  // Drive at posedge+1, return at the following negedge for sampling.
  task automatic drive(input logic [3:0] v, input logic [3:0] t, input logic r);
    req_valid = v;
    req_tail  = t;
    out_ready = r;
    #4;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_g;
    arst = 1'b1;
    req_valid = '0; req_tail = '0; out_ready = 1'b0;
    tick;

    // reset gates outputs even with requests present
    drive(4'b1111, 4'b1111, 1'b1);
    chk_out("rst", 4'b0000, 1'b0, 1'b0);
    chk("rst.rdy", req_ready, 4'b0000);
    chk("rst.tmo", timeout, 1'b0);
    tick;
    arst = 1'b0;

    drive(4'b0000, 4'b0000, 1'b1);
    chk_out("idle", 4'b0000, 1'b0, 1'b0);
    tick;

    // single-flit fairness from rr_ptr = 0
    exp_g = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      chk_out($sformatf("rr%0d", i), exp_g, 1'b1, 1'b0);
      exp_g = {exp_g[2:0], exp_g[3]};
      tick;
    end

    // idle grant tracks requests while stalled, pointer unaffected
    drive(4'b0010, 4'b0000, 1'b0);
    chk("stall_idle.gnt", grant, 4'b0010);
    chk("stall_idle.rdy", req_ready, 4'b0000);
    tick;
    drive(4'b1000, 4'b0000, 1'b0);
    chk("stall_idle2.gnt", grant, 4'b1000);
    tick;

    // req 0 four-flit packet with req 2 waiting
    for (int f = 0; f < 4; f++) begin
      drive(4'b0101, (f == 3) ? 4'b0001 : 4'b0000, 1'b1);
      chk_out($sformatf("worm%0d", f), 4'b0001, 1'b1, f != 0);
      tick;
    end
    drive(4'b0100, 4'b0000, 1'b1);
    chk_out("worm_next", 4'b0100, 1'b1, 1'b0);
    tick;

    // backpressure mid-packet, owner 2
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b0000, 1'b0);
      chk_out($sformatf("bp%0d", i), 4'b0100, 1'b1, 1'b1);
      chk($sformatf("bp%0d.rdy", i), req_ready, 4'b0000);
      tick;
    end
    // owner bubble
    for (int i = 0; i < 2; i++) begin
      drive(4'b1011, 4'b0000, 1'b1);
      chk_out($sformatf("bub%0d", i), 4'b0100, 1'b0, 1'b1);
      tick;
    end
    drive(4'b0100, 4'b0100, 1'b1);
    chk_out("bp_tail", 4'b0100, 1'b1, 1'b1);
    chk("bp_tail.rdy", req_ready, 4'b0100);
    tick;

    // pointer wrap: owner 3 tails, lane 0 next
    drive(4'b1001, 4'b0000, 1'b1);
    chk_out("wrap_head", 4'b1000, 1'b1, 1'b0);
    tick;
    drive(4'b1001, 4'b1000, 1'b1);
    chk_out("wrap_tail", 4'b1000, 1'b1, 1'b1);
    tick;
    drive(4'b1001, 4'b0001, 1'b1);
    chk_out("wrap_next", 4'b0001, 1'b1, 1'b0);
    tick;

    // reset mid-packet drops lock and rewinds pointer (was 1)
    drive(4'b0100, 4'b0000, 1'b1);
    chk_out("mrst_head", 4'b0100, 1'b1, 1'b0);
    tick;
    drive(4'b1111, 4'b0000, 1'b1);
    chk_out("mrst_lock", 4'b0100, 1'b1, 1'b1);
    tick;
    arst = 1'b1;
    drive(4'b1111, 4'b0000, 1'b1);
    chk_out("mrst_hold", 4'b0000, 1'b0, 1'b0);
    chk("mrst_hold.rdy", req_ready, 4'b0000);
    tick;
    arst = 1'b0;
    drive(4'b1111, 4'b1111, 1'b0);
    chk_out("mrst_after", 4'b0001, 1'b1, 1'b0);
    tick;

    // owner 1 locks then stalls eight cycles with req 2 waiting
    drive(4'b0010, 4'b0000, 1'b1);
    chk_out("to_head", 4'b0010, 1'b1, 1'b0);
    tick;
    for (int i = 0; i < 8; i++) begin
      drive(4'b0100, 4'b0000, 1'b1);
      chk_out($sformatf("to_stall%0d", i), 4'b0010, 1'b0, 1'b1);
      chk($sformatf("to_stall%0d.tmo", i), timeout, 1'b0);
      tick;
    end
`ifdef ARB_TIMEOUT_EN
    drive(4'b0100, 4'b0100, 1'b1);
    chk("to_pulse", timeout, 1'b1);
    chk_out("to_next", 4'b0100, 1'b1, 1'b0);
    tick;
    drive(4'b0000, 4'b0000, 1'b1);
    chk("to_end", timeout, 1'b0);
    tick;
`else
    drive(4'b0100, 4'b0100, 1'b1);
    chk("to_none", timeout, 1'b0);
    chk_out("to_held", 4'b0010, 1'b0, 1'b1);
    tick;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
